// File: rtl/ftb_pkg.sv
// ============================================================================
// Module      : ftb_pkg
// Description : Shared types and default sizing for the FFT transpose buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ftb_pkg;

    localparam int FTB_WL    = 10;
    localparam int FTB_N     = 80;
    localparam int FTB_BURST = 16;
    localparam int FTB_GAP   = 24;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } ftb_state_e;

endpackage

`default_nettype wire

// File: rtl/fft_transpose_buffer_if.sv
// ============================================================================
// Module      : fft_transpose_buffer_if
// Description : FFT-side bus of the transpose buffer: captured FFT output in,
//               column-ordered words and status out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_transpose_buffer_if
    import ftb_pkg::*;
#(
    parameter int WL = FTB_WL
);

    logic              done;
    logic [WL-1:0]     out_r;
    logic [WL-1:0]     out_i;
    logic [2*WL-1:0]   fft_in;
    logic              fft_start;
    logic              busy;
    logic              frame_done;
    logic              ovf;

    // master = FFT/environment side, slave = the transpose buffer
    modport master (
        output done,
        output out_r,
        output out_i,
        input  fft_in,
        input  fft_start,
        input  busy,
        input  frame_done,
        input  ovf
    );

    modport slave (
        input  done,
        input  out_r,
        input  out_i,
        output fft_in,
        output fft_start,
        output busy,
        output frame_done,
        output ovf
    );

endinterface

`default_nettype wire

// File: rtl/ftb_frame_ram.sv
// ============================================================================
// Module      : ftb_frame_ram
// Description : Single-port frame store with write enable and a registered,
//               read-enabled output that holds between reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ftb_frame_ram
    import ftb_pkg::*;
#(
    parameter int DW    = 2 * FTB_WL,
    parameter int DEPTH = FTB_N * FTB_N,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Storage is deliberately not reset so a reset never costs a frame clear.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fft_transpose_buffer.sv
// ============================================================================
// Module      : fft_transpose_buffer
// Description : Captures an N x N complex frame row-major from the FFT output,
//               then replays it column-major in paced bursts to the FFT input.
//               Optional macro FTB_SCALE_EN halves each component on capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_transpose_buffer
    import ftb_pkg::*;
#(
    parameter int WL    = FTB_WL,
    parameter int N     = FTB_N,
    parameter int BURST = FTB_BURST,
    parameter int GAP   = FTB_GAP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_transpose_buffer_if.slave bus
);

    // N*N must be a whole number of bursts; the last burst is never partial.
    localparam int DEPTH  = N * N;
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = $clog2(N);
    localparam int PERIOD = BURST + GAP;
    localparam int PHW    = $clog2(PERIOD + 1);

    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW-1:0]  IDX_LAST  = PW'(N - 1);
    localparam logic [PHW-1:0] PH_LAST   = PHW'(PERIOD - 1);
    localparam logic [PHW-1:0] PH_BURST  = PHW'(BURST);

    ftb_state_e      state_q,  state_d;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [PW-1:0]   p_q,      p_d;
    logic [PW-1:0]   m_q,      m_d;
    logic [PHW-1:0]  phase_q,  phase_d;
    logic            rd_vld_q, rd_vld_d;
    logic            ovf_q,    ovf_d;
    logic            rel_q,    rel_d;

    logic            w_fill_wr;
    logic            w_rd_issue;
    logic            w_last_rd;
    logic [AW-1:0]   w_rd_addr;
    logic [AW-1:0]   w_ram_addr;
    logic [2*WL-1:0] w_ram_wdata;
    logic [2*WL-1:0] w_ram_rdata;
    logic signed [WL-1:0] w_wr_r;
    logic signed [WL-1:0] w_wr_i;

    // rel_q gates all activity for the first edge after reset release, so
    // the earliest capture lands on the second rising edge.
    always_comb begin
        w_fill_wr  = rel_q && (state_q == ST_FILL) && bus.done;
        w_rd_issue = rel_q && (state_q == ST_DRAIN) && (phase_q < PH_BURST);
        w_last_rd  = w_rd_issue && (p_q == IDX_LAST) && (m_q == IDX_LAST);
        w_rd_addr  = AW'(p_q) * AW'(N) + AW'(m_q);
        w_ram_addr = (state_q == ST_FILL) ? wr_cnt_q : w_rd_addr;
    end

`ifdef FTB_SCALE_EN
    always_comb begin
        w_wr_r = $signed(bus.out_r) >>> 1;
        w_wr_i = $signed(bus.out_i) >>> 1;
    end
`else
    always_comb begin
        w_wr_r = bus.out_r;
        w_wr_i = bus.out_i;
    end
`endif

    assign w_ram_wdata = {w_wr_r, w_wr_i};

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (w_fill_wr && (wr_cnt_q == LAST_ADDR)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_rd) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_FILL;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_comb begin
        bus.busy       = (state_q == ST_DRAIN);
        bus.frame_done = (state_q == ST_FLUSH);
        bus.fft_start  = rd_vld_q;
        bus.fft_in     = w_ram_rdata;
    end

    // ------------------------------------------------------------------
    // Counters and status
    // ------------------------------------------------------------------
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        p_d      = p_q;
        m_d      = m_q;
        phase_d  = '0;
        rd_vld_d = w_rd_issue;
        ovf_d    = ovf_q | (rel_q && bus.done && (state_q != ST_FILL));
        rel_d    = 1'b1;

        if (w_fill_wr) begin
            wr_cnt_d = (wr_cnt_q == LAST_ADDR) ? '0 : wr_cnt_q + AW'(1);
        end

        // Pacing runs only while draining and restarts at 0 on each entry.
        if (rel_q && (state_q == ST_DRAIN)) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PHW'(1);
        end

        // p walks down a column; m steps to the next column when p wraps.
        if (w_rd_issue) begin
            if (p_q == IDX_LAST) begin
                p_d = '0;
                m_d = (m_q == IDX_LAST) ? '0 : m_q + PW'(1);
            end else begin
                p_d = p_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            p_q      <= '0;
            m_q      <= '0;
            phase_q  <= '0;
            rd_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            p_q      <= p_d;
            m_q      <= m_d;
            phase_q  <= phase_d;
            rd_vld_q <= rd_vld_d;
            ovf_q    <= ovf_d;
            rel_q    <= rel_d;
        end
    end

    assign bus.ovf = ovf_q;

    ftb_frame_ram #(
        .DW    (2 * WL),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_frame_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_fill_wr),
        .re    (w_rd_issue),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_fft_transpose_buffer.sv
// ============================================================================
// Module      : tb_fft_transpose_buffer
// Description : Directed self-checking bench for fft_transpose_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_transpose_buffer;

    localparam int WL = 10;
    localparam int N  = 80;
    localparam int NN = N * N;

`ifdef FTB_SCALE_EN
    localparam logic [19:0] EXP_W15 = 20'h00058;
    localparam logic [19:0] EXP_D0  = 20'hFF802;
`else
    localparam logic [19:0] EXP_W15 = 20'h004B0;
    localparam logic [19:0] EXP_D0  = 20'hFF405;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fft_transpose_buffer_if #(.WL(WL)) bus();

    fft_transpose_buffer #(
        .WL    (WL),
        .N     (N),
        .BURST (16),
        .GAP   (24)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word written at address a of a frame of the given kind
    function automatic logic [19:0] raw_val(input int kind, input int a);
        case (kind)
            0:       return 20'(a);
            1:       return 20'(a) ^ 20'hA5A5A;
            default: return (a == 0) ? 20'hFF405 : 20'(a * 3);
        endcase
    endfunction

    function automatic logic [19:0] exp_of(input logic [19:0] raw);
        logic signed [9:0] r;
        logic signed [9:0] i;
        r = raw[19:10];
        i = raw[9:0];
`ifdef FTB_SCALE_EN
        r = r >>> 1;
        i = i >>> 1;
`endif
        return {r, i};
    endfunction

    task automatic fill(input int kind, input int n);
        for (int a = 0; a < n; a++) begin
            @(negedge clk);
            if (a == 0) begin
                check("fill_start_busy", bus.busy, 0);
                check("fill_start_fdone", bus.frame_done, 0);
            end
            if (a == NN - 1) check("busy_before_last", bus.busy, 0);
            {bus.out_r, bus.out_i} = raw_val(kind, a);
            bus.done = 1'b1;
        end
        if (n == NN) begin
            @(negedge clk);
            bus.done = 1'b0;
            check("busy_rise", bus.busy, 1);
            check("start_low_at_entry", bus.fft_start, 0);
        end
    endtask

    task automatic drain(input int kind, input bit inject, input bit ovf_start);
        int k = 0;
        int hi = 0;
        int lo = 0;
        int bursts = 0;
        int bad = 0;
        int addr;
        bit seen = 1'b0;
        bit fin = 1'b0;
        for (int cyc = 1; cyc <= 20000 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 50) begin
                check("ovf_before", bus.ovf, ovf_start);
                if (inject) begin
                    bus.out_r = 10'h155;
                    bus.out_i = 10'h2AA;
                    bus.done  = 1'b1;
                end
            end
            if (cyc == 51) begin
                bus.done = 1'b0;
                check("ovf_set", bus.ovf, ovf_start | inject);
            end
            if (bus.fft_start) begin
                if (seen && lo != 0 && lo != 24) bad++;
                lo = 0;
                hi++;
                seen = 1'b1;
                if (k < NN) begin
                    addr = (k % N) * N + k / N;
                    check("word", bus.fft_in, exp_of(raw_val(kind, addr)));
                    if (kind == 0 && k == 15) check("first_burst_end", bus.fft_in, EXP_W15);
                    if (kind == 2 && k == 0)  check("scale_word0", bus.fft_in, EXP_D0);
                end
                k++;
            end else begin
                if (hi != 0) begin
                    if (hi != 16) bad++;
                    bursts++;
                end
                hi = 0;
                lo++;
            end
            if (bus.frame_done) begin
                fin = 1'b1;
                if (hi != 0) begin
                    if (hi != 16) bad++;
                    bursts++;
                end
                check("last_word_aligned", bus.fft_start, 1);
                check("busy_fall", bus.busy, 0);
            end
        end
        check("drain_finished", fin, 1);
        check("word_count", k, NN);
        check("burst_count", bursts, NN / 16);
        check("bad_runs", bad, 0);
        check("ovf_end", bus.ovf, ovf_start | inject);
    endtask

    initial begin
        bus.done  = 1'b0;
        bus.out_r = '0;
        bus.out_i = '0;
        rst_n     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_fft_in", bus.fft_in, 0);
        check("rst_fft_start", bus.fft_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame A: value = address, with a stray done during drain
        fill(0, NN);
        drain(0, 1'b1, 1'b0);

        // Frame B starts in the FILL cycle right after frame_done
        fill(1, NN);
        drain(1, 1'b0, 1'b1);

        // Frame C abandoned by an asynchronous reset at word 3000
        fill(0, 3000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fft_in", bus.fft_in, 0);
        check("arst_fft_start", bus.fft_start, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_frame_done", bus.frame_done, 0);
        check("arst_ovf", bus.ovf, 0);
        {bus.out_r, bus.out_i} = 20'h12345;
        bus.done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame D: garbage on the first edge after release must be ignored
        fill(2, NN);
        drain(2, 1'b0, 1'b0);
        @(negedge clk);
        check("fdone_single", bus.frame_done, 0);
        check("idle_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_transpose_buffer.md
FFT_TRANSPOSE_BUFFER -- requirements
Module: fft_transpose_buffer

Interface
REQ-001 Parameter WL, default 10: bit width of each real/imag component.
REQ-002 Parameter N, default 80: frame side; frame holds N*N complex words.
REQ-003 Parameter BURST, default 16: words driven per active burst.
REQ-004 Parameter GAP, default 24: idle cycles between bursts.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 done  input  1  FFT output-valid; capture out_r/out_i when high.
REQ-008 out_r  input  WL  FFT real output, two's complement.
REQ-009 out_i  input  WL  FFT imaginary output, two's complement.
REQ-010 fft_in  output  2*WL  word to FFT input, {real, imag}.
REQ-011 fft_start  output  1  high while fft_in carries a valid word.
REQ-012 busy  output  1  high in DRAIN.
REQ-013 frame_done  output  1  one-cycle pulse after last column word is driven.
REQ-014 ovf  output  1  sticky: done seen outside FILL.

Function
REQ-015 FSM states SHALL be FILL, DRAIN, FLUSH; reset state FILL.
REQ-016 FILL: each cycle with done=1 SHALL write {out_r,out_i} at address wr_cnt, then wr_cnt+1 (row-major order).
REQ-017 Write of address N*N-1 SHALL move FSM to DRAIN on the next edge; wr_cnt SHALL return to 0.
REQ-018 DRAIN: read address SHALL be N*p+m; p (0..N-1) increments per word, m increments when p wraps from N-1 to 0.
REQ-019 DRAIN pacing: phase counter 0..BURST+GAP-1 repeating, starting at 0 on DRAIN entry; reads issued in phases 0..BURST-1 only.
REQ-020 RAM read latency 1 cycle; fft_start SHALL be the read-issue strobe delayed 1 cycle, aligned with fft_in.
REQ-021 fft_in SHALL hold its last value when fft_start=0.
REQ-022 After the read with m=N-1, p=N-1, FSM SHALL enter FLUSH for exactly 1 cycle, pulse frame_done in that cycle, then return to FILL.
REQ-023 done=1 in DRAIN or FLUSH SHALL be ignored (no write) and SHALL set ovf.
REQ-024 done=1 in the FILL cycle immediately after FLUSH SHALL be accepted as word 0 of the next frame.
REQ-025 N*N SHALL be a multiple of BURST; a final partial burst is not supported.

Reset
REQ-026 rst_n low SHALL immediately force: state FILL; wr_cnt, p, m, phase = 0; fft_in = 0; fft_start, busy, frame_done, ovf = 0.
REQ-027 Reset mid-FILL or mid-DRAIN SHALL abandon the frame; RAM contents are not cleared.
REQ-028 Deassertion SHALL be synchronized; first capture possible on the second rising edge after release.

Configuration
REQ-029 Macro FTB_SCALE_EN defined: out_r and out_i SHALL each be arithmetic-shifted right by 1 (truncation) before write.
REQ-030 FTB_SCALE_EN undefined: values SHALL be written unmodified.

Structure
REQ-031 Shared package ftb_pkg SHALL hold the state enum typedef and default constants WL=10, N=80, BURST=16, GAP=24.
REQ-032 One sub-module ftb_frame_ram: single-port synchronous RAM, N*N x 2*WL, write-enable, 1-cycle registered read; FILL and DRAIN never access it together.

Verification
REQ-033 Fill 6400 words value = address, done held high -> busy rises 1 cycle after last write; first 16 fft_in = 0,80,160,...,1200 with fft_start high.
REQ-034 Full drain -> fft_start high 16 cycles, low 24 cycles, repeated 400 times; frame_done one pulse; 6400th word = 6399; return to FILL.
REQ-035 done pulsed during DRAIN at cycle 50 -> no RAM change, ovf=1 and stays 1 until reset.
REQ-036 rst_n low at word 3000 of FILL -> all outputs 0 asynchronously; after release new 6400-word fill drains correctly from address 0.
REQ-037 FTB_SCALE_EN defined, out_r=-3, out_i=5 at address 0 -> first fft_in = {-2, 2}; undefined -> {-3, 5}.
REQ-038 done high in FILL cycle directly after frame_done -> stored at address 0; second frame drains correctly.
